// File: rtl/tft_pkg.sv
// Shared definitions for the TFT display path: SPI transmitter state encoding,
// SPI mode constants and panel geometry used by the scene/init producers.
package tft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LINGER
  } tft_state_e;

  // SPI mode 0: SCK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int TFT_BYTES_PER_PIXEL = 3;
  localparam int TFT_WIDTH           = 320;
  localparam int TFT_HEIGHT          = 480;

endpackage

// File: rtl/tft_spi_transmitter.sv
// Byte-wide producer interface to the TFT 4-wire SPI pins (SCK, MOSI, CS_n, DC).
// Handshake: a byte is taken on any clk edge where tft_transmit=1 and tft_busy=0;
// tft_busy is high from the next cycle until the last SCK falling edge, and
// requests seen while busy are dropped.
module tft_spi_transmitter
  import tft_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int CS_LINGER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  input  logic       tft_transmit,
  output logic       tft_busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output tft_state_e dbg_state
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int LW = (CS_LINGER > 0) ? $clog2(CS_LINGER + 1) : 1;
  localparam logic [HW-1:0] HALF_LAST   = HW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LINGER_LAST = LW'((CS_LINGER > 0) ? CS_LINGER - 1 : 0);

  tft_state_e    state;
  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [LW-1:0] linger_cnt;
  logic [7:0]    shreg;
  logic          accept;

  assign accept    = tft_transmit && ((state == IDLE) || (state == LINGER));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      linger_cnt <= '0;
      shreg      <= '0;
      tft_busy   <= 1'b0;
      spi_sck    <= SPI_CPOL;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dc     <= 1'b0;
    end else begin
      case (state)
        IDLE, LINGER: begin
          if (accept) begin
            // Entering from LINGER keeps CS_n low so multi-byte pixels stay framed.
            shreg    <= tft_data;
            spi_dc   <= tft_dc;
            spi_mosi <= tft_data[7];
            spi_cs_n <= 1'b0;
            tft_busy <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT_LO;
          end else if (state == LINGER) begin
            if (linger_cnt == LINGER_LAST) begin
              spi_cs_n <= 1'b1;
              state    <= IDLE;
            end else begin
              linger_cnt <= linger_cnt + 1'b1;
            end
          end
        end
        SHIFT_LO: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            spi_sck  <= ~SPI_CPOL;
            state    <= SHIFT_HI;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            spi_sck  <= SPI_CPOL;
            if (bit_cnt == 3'd7) begin
              tft_busy <= 1'b0;
              bit_cnt  <= '0;
              if (CS_LINGER == 0) begin
                spi_cs_n <= 1'b1;
                state    <= IDLE;
              end else begin
                linger_cnt <= '0;
                state      <= LINGER;
              end
            end else begin
              // Next bit changes on the falling edge, a full half-period before it is sampled.
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
              state    <= SHIFT_LO;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi_transmitter.sv
// Bench for tft_spi_transmitter: one instance with default timing (d=0) and one
// corner instance with CLK_DIV=1, CS_LINGER=0 (d=1), sharing clk and rst.
module tb_tft_spi_transmitter;
  import tft_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tx, dcin, busy, sck, mosi, cs_n, dcp;
  logic [7:0] tdata [2];
  tft_state_e st [2];

  int n_vec = 0;
  int n_err = 0;

  // Expected {dut, dc, byte}; received {frame_ok, dut, dc, byte}.
  logic [9:0]  exp_q[$];
  logic [10:0] rx_q[$];

  always #5 clk = ~clk;

  tft_spi_transmitter #(.CLK_DIV(2), .CS_LINGER(4)) u_dut0 (
    .clk(clk), .rst(rst), .tft_dc(dcin[0]), .tft_data(tdata[0]),
    .tft_transmit(tx[0]), .tft_busy(busy[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
    .spi_cs_n(cs_n[0]), .spi_dc(dcp[0]), .dbg_state(st[0])
  );

  tft_spi_transmitter #(.CLK_DIV(1), .CS_LINGER(0)) u_dut1 (
    .clk(clk), .rst(rst), .tft_dc(dcin[1]), .tft_data(tdata[1]),
    .tft_transmit(tx[1]), .tft_busy(busy[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
    .spi_cs_n(cs_n[1]), .spi_dc(dcp[1]), .dbg_state(st[1])
  );

  function automatic int cd(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int lg(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  // SPI receiver: samples MOSI at each SCK rising edge, like the panel would.
  logic [7:0] acc [2];
  int         nb [2];
  logic       pdc [2];
  bit         okf [2];
  logic [1:0] psck = 2'b00;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nb[d] = 0;
      end else if (sck[d] && !psck[d]) begin
        if (nb[d] == 0) begin
          okf[d] = 1'b1;
          pdc[d] = dcp[d];
        end
        if (dcp[d] !== pdc[d] || cs_n[d] !== 1'b0) okf[d] = 1'b0;
        acc[d] = {acc[d][6:0], mosi[d]};
        nb[d]++;
        if (nb[d] == 8) begin
          rx_q.push_back({okf[d], 1'(d), pdc[d], acc[d]});
          nb[d] = 0;
        end
      end
      psck[d] = sck[d];
    end
  end

  // Driver: one-cycle pulse, then measure busy width; ends on the first busy=0 cycle.
  task automatic xfer(input int d, input logic dc, input logic [7:0] data,
                      output int bw, output bit cs_hi);
    @(negedge clk);
    tdata[d] = data;
    dcin[d]  = dc;
    tx[d]    = 1'b1;
    exp_q.push_back({1'(d), dc, data});
    @(negedge clk);
    tx[d] = 1'b0;
    bw = 0;
    cs_hi = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy[d]) break;
      bw++;
      if (cs_n[d]) cs_hi = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic linger(input int d, output int lc);
    lc = 0;
    for (int i = 0; i < 200; i++) begin
      if (cs_n[d]) break;
      lc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (busy[d] !== 1'b0) begin n_err++; $display("FAIL reset busy[%0d]: got %b want 0", d, busy[d]); end
      n_vec++; if (sck[d] !== 1'b0) begin n_err++; $display("FAIL reset sck[%0d]: got %b want 0", d, sck[d]); end
      n_vec++; if (mosi[d] !== 1'b0) begin n_err++; $display("FAIL reset mosi[%0d]: got %b want 0", d, mosi[d]); end
      n_vec++; if (cs_n[d] !== 1'b1) begin n_err++; $display("FAIL reset cs_n[%0d]: got %b want 1", d, cs_n[d]); end
      n_vec++; if (dcp[d] !== 1'b0) begin n_err++; $display("FAIL reset dc[%0d]: got %b want 0", d, dcp[d]); end
      n_vec++; if (st[d] !== IDLE) begin n_err++; $display("FAIL reset state[%0d]: got %0d want IDLE", d, st[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int bw, lc;
    bit ch;
    logic [9:0] e;
    logic [10:0] r;
    xfer(0, 1'b1, 8'hA5, bw, ch);
    n_vec++; if (bw != 32) begin n_err++; $display("FAIL single busy width: got %0d want 32", bw); end
    n_vec++; if (ch) begin n_err++; $display("FAIL single cs during byte: got high want low"); end
    linger(0, lc);
    n_vec++; if (lc != 4) begin n_err++; $display("FAIL single linger: got %0d want 4", lc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL single rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL single rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL single extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_back_to_back;
    int bw, lc;
    bit ch;
    logic [7:0] px [$];
    logic [9:0] e;
    logic [10:0] r;
    px = '{8'h3A, 8'h7B, 8'hD5};
    repeat (6) px.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < px.size(); i++) begin
      xfer(0, 1'b1, px[i], bw, ch);
      n_vec++; if (bw != 32 || ch) begin n_err++; $display("FAIL b2b byte %0d: busy %0d cs_hi %b want 32 0", i, bw, ch); end
      n_vec++; if (cs_n[0] !== 1'b0) begin n_err++; $display("FAIL b2b cs held after byte %0d: got %b want 0", i, cs_n[0]); end
    end
    linger(0, lc);
    n_vec++; if (lc != 4) begin n_err++; $display("FAIL b2b linger: got %0d want 4", lc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL b2b rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL b2b rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL b2b extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_ignore_busy;
    int bw, lc;
    logic [9:0] e;
    logic [10:0] r;
    @(negedge clk);
    tdata[0] = 8'h00; dcin[0] = 1'b1; tx[0] = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    @(negedge clk);
    tx[0] = 1'b0;
    bw = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy[0]) break;
      bw++;
      if (bw == 10) begin tdata[0] = 8'hFF; tx[0] = 1'b1; end
      else tx[0] = 1'b0;
      @(negedge clk);
    end
    tx[0] = 1'b0;
    n_vec++; if (bw != 32) begin n_err++; $display("FAIL ignore busy width: got %0d want 32", bw); end
    linger(0, lc);
    n_vec++; if (lc != 4) begin n_err++; $display("FAIL ignore linger: got %0d want 4", lc); end
    repeat (40) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL ignore rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL ignore rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL ignore extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_cmd_data;
    int bw, lc;
    bit ch;
    logic [9:0] e;
    logic [10:0] r;
    xfer(0, 1'b0, 8'h2C, bw, ch);
    n_vec++; if (bw != 32) begin n_err++; $display("FAIL cmd busy width: got %0d want 32", bw); end
    xfer(0, 1'b1, 8'h12, bw, ch);
    n_vec++; if (bw != 32) begin n_err++; $display("FAIL data busy width: got %0d want 32", bw); end
    linger(0, lc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL cmd_data rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL cmd_data rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL cmd_data extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_reset_mid;
    int bw, lc, nr;
    bit ch;
    logic ps;
    logic [9:0] e;
    logic [10:0] r;
    @(negedge clk);
    tdata[0] = 8'hB7; dcin[0] = 1'b1; tx[0] = 1'b1;
    @(negedge clk);
    tx[0] = 1'b0;
    nr = 0; ps = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sck[0] && !ps) nr++;
      ps = sck[0];
      if (nr == 3) break;
      @(negedge clk);
    end
    n_vec++; if (mosi[0] !== 1'b1) begin n_err++; $display("FAIL mid bit3 mosi: got %b want 1", mosi[0]); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (cs_n[0] !== 1'b1) begin n_err++; $display("FAIL mid reset cs_n: got %b want 1", cs_n[0]); end
    n_vec++; if (sck[0] !== 1'b0) begin n_err++; $display("FAIL mid reset sck: got %b want 0", sck[0]); end
    n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL mid reset busy: got %b want 0", busy[0]); end
    n_vec++; if (mosi[0] !== 1'b0) begin n_err++; $display("FAIL mid reset mosi: got %b want 0", mosi[0]); end
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 1'b1, 8'h5A, bw, ch);
    n_vec++; if (bw != 32) begin n_err++; $display("FAIL after reset busy width: got %0d want 32", bw); end
    linger(0, lc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL reset_mid rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL reset_mid rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL reset_mid extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_corner;
    int bw, lc;
    bit ch;
    logic [9:0] e;
    logic [10:0] r;
    xfer(1, 1'b1, 8'hC3, bw, ch);
    n_vec++; if (bw != 16) begin n_err++; $display("FAIL corner busy width: got %0d want 16", bw); end
    linger(1, lc);
    n_vec++; if (lc != 0) begin n_err++; $display("FAIL corner cs release: got %0d want 0", lc); end
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b1, 8'($urandom_range(0, 255)), bw, ch);
      n_vec++; if (bw != 16 || ch) begin n_err++; $display("FAIL corner stream %0d: busy %0d cs_hi %b want 16 0", i, bw, ch); end
      n_vec++; if (cs_n[1] !== 1'b1) begin n_err++; $display("FAIL corner cs toggle %0d: got %b want 1", i, cs_n[1]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL corner rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL corner rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL corner extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_random;
    int bw, lc;
    bit ch;
    logic [9:0] e;
    logic [10:0] r;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        xfer(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), bw, ch);
        n_vec++; if (bw != 16 * cd(d)) begin n_err++; $display("FAIL random busy width d%0d: got %0d want %0d", d, bw, 16 * cd(d)); end
      end
      linger(d, lc);
      n_vec++; if (lc != lg(d)) begin n_err++; $display("FAIL random linger d%0d: got %0d want %0d", d, lc, lg(d)); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (rx_q.size() == 0) begin n_err++; $display("FAIL random rx: got none want %h", e); end
      else begin r = rx_q.pop_front(); if (r !== {1'b1, e}) begin n_err++; $display("FAIL random rx: got %h want %h", r, {1'b1, e}); end end
    end
    n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL random extra bytes: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  initial begin
    tx = '0;
    dcin = '0;
    tdata[0] = '0;
    tdata[1] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_cmd_data();
    test_reset_mid();
    test_corner();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
